// File: rtl/bist_pkg.sv
// Shared definitions for the BIST requester and the BIST controller bench.
// Contents:
//   bist_state_e       requester FSM states
//   BIST_SEQ_LEN       nominal controller sequence length in cycles
//   BIST_TIMEOUT_DFLT  default sequence timeout in cycles
//   BIST_CNT_W_DFLT    default width of run and cycle counters
//   bist_state_active  true in the states where bist_start is requested
package bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ      = 3'd1,
    ST_WAIT_END = 3'd2,
    ST_GAP      = 3'd3,
    ST_DONE     = 3'd4,
    ST_ERROR    = 3'd5
  } bist_state_e;

  localparam int BIST_SEQ_LEN      = 90;
  localparam int BIST_TIMEOUT_DFLT = 128;
  localparam int BIST_CNT_W_DFLT   = 8;

  // REQ and WAIT_END share the request level and the timeout window.
  function automatic logic bist_state_active(input bist_state_e s);
    return (s == ST_REQ) || (s == ST_WAIT_END);
  endfunction

endpackage

// File: rtl/bist_cycle_timer.sv
// Saturating cycle counter with a terminal-count compare.
// Ports:
//   clock, reset  rising-edge clock, async active-high reset (count -> 0)
//   load          synchronous clear to 0, has priority over en
//   en            count up by one per cycle, sticks at all-ones
//   limit         compare value
//   expired       count == limit (combinational from the count flop)
module bist_cycle_timer
  import bist_pkg::*;
#(
  parameter int CNT_W = BIST_CNT_W_DFLT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_q;

  // Next count: clear, increment until saturated, or hold.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = '0;
    end else if (en && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == limit);

endmodule

// File: rtl/bist_requester.sv
// Host-side initiator for the BIST controller: runs NUM_RUNS sequences per
// go request, each guarded by a timeout, with GAP_CYCLES of idle request
// between sequences.
// Ports:
//   clock, reset   rising-edge clock, async active-high reset
//   go             batch start, honoured in IDLE/DONE/ERROR only
//   abort          synchronous cancel to IDLE, beats every other event
//   running        controller is executing a sequence
//   bist_end       controller finished a sequence
//   bist_start     level request to the controller
//   busy           high in REQ, WAIT_END, GAP
//   done           batch completed, held until next go
//   timeout_err    sequence timed out, held until next go
//   runs_done      sequences completed in the current batch
module bist_requester
  import bist_pkg::*;
#(
  parameter int NUM_RUNS       = 4,
  parameter int TIMEOUT_CYCLES = BIST_TIMEOUT_DFLT,
  parameter int GAP_CYCLES     = 2,
  parameter int CNT_W          = BIST_CNT_W_DFLT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             go,
  input  logic             abort,
  input  logic             running,
  input  logic             bist_end,
  output logic             bist_start,
  output logic             busy,
  output logic             done,
  output logic             timeout_err,
  output logic [CNT_W-1:0] runs_done
);

  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES >= (1 << CNT_W))) begin : g_bad_timeout
    $fatal(1, "bist_requester: TIMEOUT_CYCLES must be 1..2^CNT_W-1");
  end
  if ((NUM_RUNS < 1) || (NUM_RUNS >= (1 << CNT_W))) begin : g_bad_runs
    $fatal(1, "bist_requester: NUM_RUNS must be 1..2^CNT_W-1");
  end
  if ((GAP_CYCLES < 1) || (GAP_CYCLES >= (1 << CNT_W))) begin : g_bad_gap
    $fatal(1, "bist_requester: GAP_CYCLES must be 1..2^CNT_W-1");
  end

  // The timers start at 0 on entry, so the last legal cycle is limit-1.
  localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LIMIT = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUNS_LAST = CNT_W'(NUM_RUNS);

  bist_state_e      state_d, state_q;
  logic [CNT_W-1:0] runs_done_d, runs_done_q;
  logic [CNT_W-1:0] runs_done_inc;
  logic             bist_start_d, bist_start_q;
  logic             busy_d, busy_q;
  logic             done_d, done_q;
  logic             timeout_err_d, timeout_err_q;
  logic             tmo_load, tmo_en, tmo_expired;
  logic             gap_load, gap_en, gap_expired;

  assign runs_done_inc = runs_done_q + CNT_W'(1);

  // Next state, run count, decoded outputs and timer controls.
  always_comb begin
    state_d     = state_q;
    runs_done_d = runs_done_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (go) begin
            state_d     = ST_REQ;
            runs_done_d = '0;
          end else begin
            state_d = state_q;
          end
        end
        ST_REQ: begin
          if (running) begin
            state_d = ST_WAIT_END;
          end else if (tmo_expired) begin
            state_d = ST_ERROR;
          end else begin
            state_d = ST_REQ;
          end
        end
        ST_WAIT_END: begin
          // A completion in the expiry cycle still counts.
          if (bist_end) begin
            runs_done_d = runs_done_inc;
            if (runs_done_inc == RUNS_LAST) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_GAP;
            end
          end else if (tmo_expired) begin
            state_d = ST_ERROR;
          end else begin
            state_d = ST_WAIT_END;
          end
        end
        ST_GAP: begin
          if (gap_expired) begin
            state_d = ST_REQ;
          end else begin
            state_d = ST_GAP;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Outputs are decoded from the next state so they register with it.
    bist_start_d  = bist_state_active(state_d);
    busy_d        = bist_start_d || (state_d == ST_GAP);
    done_d        = (state_d == ST_DONE);
    timeout_err_d = (state_d == ST_ERROR);

    // Timeout window spans REQ+WAIT_END and restarts only on REQ entry.
    tmo_load = bist_state_active(state_d) && !bist_state_active(state_q);
    tmo_en   = bist_state_active(state_q);
    gap_load = (state_d == ST_GAP) && (state_q != ST_GAP);
    gap_en   = (state_q == ST_GAP);
  end

  // FSM state and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      runs_done_q   <= '0;
      bist_start_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      runs_done_q   <= runs_done_d;
      bist_start_q  <= bist_start_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  bist_cycle_timer #(.CNT_W(CNT_W)) u_tmo_timer (
    .clock   (clock),
    .reset   (reset),
    .load    (tmo_load),
    .en      (tmo_en),
    .limit   (TMO_LIMIT),
    .expired (tmo_expired)
  );

  bist_cycle_timer #(.CNT_W(CNT_W)) u_gap_timer (
    .clock   (clock),
    .reset   (reset),
    .load    (gap_load),
    .en      (gap_en),
    .limit   (GAP_LIMIT),
    .expired (gap_expired)
  );

  assign bist_start  = bist_start_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = timeout_err_q;
  assign runs_done   = runs_done_q;

endmodule
